// File: rtl/ex_core_alu_sched_if.sv
// Bundle of request, ALU and response signals between the issue sources, the
// round-robin ALU scheduler and the shared combinational ALU.
interface ex_core_alu_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0][3:0]   req_op;
   logic [NUM_REQ-1:0][31:0]  req_opnd1;
   logic [NUM_REQ-1:0][31:0]  req_opnd2;

   logic [31:0]               alu_operand1;
   logic [31:0]               alu_operand2;
   logic [3:0]                alu_op;
   logic [31:0]               alu_result;
   logic                      alu_zero;

   logic                      resp_valid;
   logic                      resp_ready;
   logic [ID_W-1:0]           resp_id;
   logic [31:0]               resp_result;
   logic                      resp_zero;
   logic                      resp_err;
   logic [CNT_W-1:0]          op_cnt;

   modport master (
      output req_valid, req_op, req_opnd1, req_opnd2,
      output alu_result, alu_zero, resp_ready,
      input  req_ready, alu_operand1, alu_operand2, alu_op,
      input  resp_valid, resp_id, resp_result, resp_zero, resp_err, op_cnt
   );

   modport slave (
      input  req_valid, req_op, req_opnd1, req_opnd2,
      input  alu_result, alu_zero, resp_ready,
      output req_ready, alu_operand1, alu_operand2, alu_op,
      output resp_valid, resp_id, resp_result, resp_zero, resp_err, op_cnt
   );
endinterface

// File: rtl/ex_core_alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between NUM_REQ requesters;
// one operation in flight, result returned with requester id on a valid/ready channel.
//
//   state | meaning
//   IDLE  | arbitrate; grant one requester and latch its operands into the ALU regs
//   EXEC  | ALU settles on registered operands; capture result/zero/err at the edge
//   RESP  | response valid; hold until consumer accepts, then count the op
module ex_core_alu_sched #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 Clk,
   input  logic                 Rst,
   ex_core_alu_sched_if.slave   bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant;
   logic              grant_vld;
   logic [ID_W-1:0]   grant_inc;
   logic [NUM_REQ-1:0] ready_c;
   logic              resp_valid_c;

   logic [31:0]       alu_operand1_q;
   logic [31:0]       alu_operand2_q;
   logic [3:0]        alu_op_q;
   logic [ID_W-1:0]   resp_id_q;
   logic [31:0]       resp_result_q;
   logic              resp_zero_q;
   logic              resp_err_q;
   logic [CNT_W-1:0]  op_cnt_q;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      logic [ID_W-1:0] idx;
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_vld && bus.req_valid[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
   end

   assign grant_inc = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready_c      = '0;
      resp_valid_c = (state == RESP);
      if (state == IDLE && grant_vld) begin
         ready_c[grant] = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rr_ptr         <= '0;
         alu_operand1_q <= '0;
         alu_operand2_q <= '0;
         alu_op_q       <= '0;
         resp_id_q      <= '0;
         resp_result_q  <= '0;
         resp_zero_q    <= 1'b0;
         resp_err_q     <= 1'b0;
         op_cnt_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  alu_op_q       <= bus.req_op[grant];
                  alu_operand1_q <= bus.req_opnd1[grant];
                  alu_operand2_q <= bus.req_opnd2[grant];
                  resp_id_q      <= grant;
                  rr_ptr         <= grant_inc;
               end
            end
            EXEC: begin
               // Opcodes 10..15 have no ALU function; report a forced zero result.
               if (alu_op_q > 4'd9) begin
                  resp_result_q <= '0;
                  resp_zero_q   <= 1'b1;
                  resp_err_q    <= 1'b1;
               end else begin
                  resp_result_q <= bus.alu_result;
                  resp_zero_q   <= bus.alu_zero;
                  resp_err_q    <= 1'b0;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  op_cnt_q <= op_cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready    = ready_c;
   assign bus.resp_valid   = resp_valid_c;
   assign bus.alu_operand1 = alu_operand1_q;
   assign bus.alu_operand2 = alu_operand2_q;
   assign bus.alu_op       = alu_op_q;
   assign bus.resp_id      = resp_id_q;
   assign bus.resp_result  = resp_result_q;
   assign bus.resp_zero    = resp_zero_q;
   assign bus.resp_err     = resp_err_q;
   assign bus.op_cnt       = op_cnt_q;
endmodule
